// File: rtl/bm_dag1_seq_ctrl.sv
// Multi-cycle dag1 sequencer: out = (a+b) + (a-b) - (b+b) through one shared add/sub unit.
// Optional sticky dropped-request flag on port err when DAG1_SEQ_ERR_EN is defined.
module bm_dag1_seq_ctrl #(
    parameter int BITS = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] out
`ifdef DAG1_SEQ_ERR_EN
    ,
    output logic            err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_SUM  = 3'd4,
        S_DIFF = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t          state_q;
    logic [BITS-1:0] a_q, b_q, t1_q, t2_q, t3_q, out_q;
    logic            busy_q, done_q;

    logic [BITS-1:0] alu_x, alu_y, alu_d;
    logic            alu_sub;

    // Operand/op selection per state; subtraction is x + ~y + 1 so only one adder exists.
    always_comb begin
        alu_x   = a_q;
        alu_y   = b_q;
        alu_sub = 1'b0;
        case (state_q)
            S_T2:   alu_sub = 1'b1;
            S_T3:   alu_x   = b_q;
            S_SUM: begin
                alu_x = t1_q;
                alu_y = t2_q;
            end
            S_DIFF: begin
                alu_x   = t1_q;
                alu_y   = t3_q;
                alu_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_d = alu_x + (alu_y ^ {BITS{alu_sub}}) + BITS'(alu_sub);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        busy_q  <= 1'b1;
                        state_q <= S_T1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_T1: begin
                    t1_q    <= alu_d;
                    state_q <= S_T2;
                end
                S_T2: begin
                    t2_q    <= alu_d;
                    state_q <= S_T3;
                end
                S_T3: begin
                    t3_q    <= alu_d;
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    t1_q    <= alu_d;
                    state_q <= S_DIFF;
                end
                S_DIFF: begin
                    out_q   <= alu_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DAG1_SEQ_ERR_EN
    logic err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (start && busy_q) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    assign busy  = busy_q;
    assign ready = ~busy_q;
    assign done  = done_q;
    assign out   = out_q;

endmodule

// File: tb/tb_bm_dag1_seq_ctrl.sv
// Scoreboard bench for bm_dag1_seq_ctrl: BITS=8 main instance plus a BITS=2 wrap instance.
// A cycle model tracks acceptance; expected results are queued on accept and popped on done.
module tb_bm_dag1_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       ready, busy, done;
    logic [7:0] out;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       ready2, busy2, done2;
    logic [1:0] out2;

`ifdef DAG1_SEQ_ERR_EN
    logic err, err2;
`endif

    always #5 clk = ~clk;

    bm_dag1_seq_ctrl #(.BITS(8)) dut (
        .clock(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .ready(ready), .busy(busy), .done(done), .out(out)
`ifdef DAG1_SEQ_ERR_EN
        , .err(err)
`endif
    );

    bm_dag1_seq_ctrl #(.BITS(2)) dut2 (
        .clock(clk), .reset(reset), .start(start2), .a_in(a2), .b_in(b2),
        .ready(ready2), .busy(busy2), .done(done2), .out(out2)
`ifdef DAG1_SEQ_ERR_EN
        , .err(err2)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dag1(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = (a + b) + (a - b) - (b + b);
        return r;
    endfunction

    // Reference cycle model: 0 = idle, 1..5 = busy steps, 6 = done cycle.
    int         m_cnt = 0;
    int         cyc = 0;
    logic [7:0] m_out = '0;
    logic [7:0] m_pend = '0;
    logic       m_err = 1'b0;
    logic [7:0] exp_q[$];
    int         acc_q[$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_cnt = 0;
            m_out = '0;
            m_err = 1'b0;
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (start && m_cnt >= 1 && m_cnt <= 5) m_err = 1'b1;
            if (m_cnt == 0 || m_cnt == 6) begin
                if (start) begin
                    m_pend = dag1(a_in, b_in);
                    exp_q.push_back(m_pend);
                    acc_q.push_back(cyc);
                    m_cnt = 1;
                end else begin
                    m_cnt = 0;
                end
            end else if (m_cnt == 5) begin
                m_cnt = 6;
                m_out = m_pend;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        int         ac;
        check("busy",  32'(busy),  32'(m_cnt >= 1 && m_cnt <= 5));
        check("ready", 32'(ready), 32'(!(m_cnt >= 1 && m_cnt <= 5)));
        check("done",  32'(done),  32'(m_cnt == 6));
        check("out",   32'(out),   32'(m_out));
`ifdef DAG1_SEQ_ERR_EN
        check("err",   32'(err),   32'(m_err));
`endif
        if (done) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_done", 32'(exp_q.size()), 32'd1);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                check("sb_out", 32'(out), 32'(e));
                check("sb_latency", 32'(cyc - ac), 32'd5);
                $display("txn: out=%0d expected=%0d latency=%0d", out, e, cyc - ac);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (!(m_cnt == 0 && exp_q.size() == 0) && n < max_cycles) begin
            tick();
            n++;
        end
        if (n >= max_cycles) check("timeout", 32'(m_cnt), 32'd0);
    endtask

    task automatic pulse(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        a_in  = 8'hAA;
        b_in  = 8'h55;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out2", 32'(out2), 32'd0);
        check("rst_ready2", 32'(ready2), 32'd1);

        // Basic 10,3 -> 14 alongside the 2-bit instance computing 3,2 -> 2.
        start2 = 1'b1;
        a2 = 2'd3;
        b2 = 2'd2;
        pulse(8'd10, 8'd3);
        start2 = 1'b0;
        a2 = 2'd0;
        b2 = 2'd0;
        wait_idle(20);
        check("bits2_out", 32'(out2), 32'd2);
        check("bits2_busy", 32'(busy2), 32'd0);

        // Wrap 3,10 -> 242.
        pulse(8'd3, 8'd10);
        wait_idle(20);
        check("wrap_out", 32'(out), 32'd242);

        // Back-to-back: hold start, change operands during busy, then 7,5 in the done cycle.
        start = 1'b1;
        a_in  = 8'd10;
        b_in  = 8'd3;
        tick();
        a_in  = 8'd50;
        b_in  = 8'd60;
        n = 0;
        while (m_cnt != 6 && n < 20) begin
            tick();
            n++;
        end
        check("b2b_reach_done", 32'(m_cnt), 32'd6);
        a_in = 8'd7;
        b_in = 8'd5;
        tick();
        start = 1'b0;
        wait_idle(20);
        check("b2b_out", 32'(out), 32'd4);

        // Dropped request in the T2 cycle.
        pulse(8'd10, 8'd3);
        tick();
        pulse(8'd100, 8'd3);
        wait_idle(20);
        check("drop_out", 32'(out), 32'd14);
`ifdef DAG1_SEQ_ERR_EN
        check("drop_err", 32'(err), 32'd1);
`endif

        // Reset during SUM discards the computation.
        pulse(8'd10, 8'd3);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        pulse(8'd7, 8'd5);
        wait_idle(20);
        check("midrst_new_out", 32'(out), 32'd4);

        // Reset and start on the same edge: nothing captured.
        reset = 1'b1;
        start = 1'b1;
        a_in  = 8'd9;
        b_in  = 8'd1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rstprio_out", 32'(out), 32'd0);
        check("rstprio_busy", 32'(busy), 32'd0);

        // Random operands with random start hold lengths.
        for (int i = 0; i < 8; i++) begin
            start = 1'b1;
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) begin
                tick();
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
            start = 1'b0;
            wait_idle(30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bm_dag1_seq_ctrl.md
# bm_dag1_seq_ctrl

Multi-cycle sequencer that evaluates the dag1 expression `out = (a_in + b_in) + (a_in - b_in) - (b_in + b_in)` using one shared add/subtract unit instead of five parallel operators. It sits in the micro benchmark suite beside the combinational dag1 datapath and exercises FSM control, operand capture, a start/done handshake and resource sharing in the synthesis flow. All arithmetic is modulo 2^BITS.

## Interface
- BITS, 2, operand and result width.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- start  input  1  request to compute; accepted only when ready is high.
- a_in  input  BITS  operand A; sampled only on the accepting edge.
- b_in  input  BITS  operand B; sampled only on the accepting edge.
- ready  output  1  high in IDLE and DONE; start is accepted only while ready is high.
- busy  output  1  high in states T1 through DIFF.
- done  output  1  one-cycle pulse, high while in DONE.
- out  output  BITS  registered result; holds its value until the next completion.
- err  output  1  sticky error flag; present only with DAG1_SEQ_ERR_EN.

## Operation
- Registers: a_r, b_r, t1, t2, t3 (BITS each), state, out_r.
- Shared ALU: a single BITS-wide unit computing x+y or x−y. Its operand muxes and op select are driven by state. Exactly one ALU operation per cycle. No second adder may be inferred.
- FSM states and transitions:
  - IDLE: if start, capture a_r=a_in and b_r=b_in, go to T1.
  - T1: t1 = a_r + b_r, go to T2.
  - T2: t2 = a_r − b_r, go to T3.
  - T3: t3 = b_r + b_r, go to SUM.
  - SUM: t1 = t1 + t2, reusing t1 as the accumulator, go to DIFF.
  - DIFF: out_r = t1 − t3, go to DONE.
  - DONE: if start, capture operands and go to T1 (back-to-back); otherwise go to IDLE.
- Width rule: every result is truncated to BITS. No carry or borrow output. Underflow wraps; for example, with BITS=8, 0 − 2 = 254.
- start while busy is high is ignored. Operands captured in flight are never disturbed, and a_in/b_in may change freely after capture.
- Reset (at any state, including mid-sequence): state=IDLE, out=0, done=0, busy=0, ready=1, err=0. The partial computation is discarded and no done pulse is produced.
- Simultaneous reset and start: reset wins; the request is not captured.

## Timing
- Accepting edge E0: start is sampled high with ready high.
- Edges E1..E5: T1, T2, T3, SUM, DIFF execute. out updates at E5. done is high during the cycle following E5.
- Latency: 5 cycles from the accepting edge to valid out and done.
- Throughput: one result per 6 cycles when start is held high, because acceptance in DONE overlaps the done cycle.
- busy rises the cycle after E0 and falls at E5. ready is the exact complement of busy.
- done never lasts more than one cycle. It is never asserted on a cycle without a fresh out value.

## Configuration
- DAG1_SEQ_ERR_EN defined:
  - err port exists.
  - err is set on any edge where start=1 and busy=1 (request dropped).
  - err stays set until reset and does not affect sequencing.
- DAG1_SEQ_ERR_EN undefined: no err port and no err register; dropped requests are silent.

## Test plan
- Basic: BITS=8, reset for 2 cycles, then one-cycle start with a_in=10, b_in=3 → done pulses exactly 5 cycles after accept, out=14, busy high for exactly 5 cycles.
- Wrap: BITS=8, a_in=3, b_in=10 → out=242. BITS=2, a_in=3, b_in=2 → out=2.
- Back-to-back: hold start=1 with a_in=10, b_in=3 and change to a_in=7, b_in=5 in the done cycle → second done 6 cycles after the first, out=4. Operands changed during busy are not captured.
- Busy drop: start pulsed in the T2 cycle with a_in=100 → first result unchanged (14), no extra done. With DAG1_SEQ_ERR_EN, err=1 from the next cycle and stays high.
- Mid-op reset: assert reset during SUM → next cycle state=IDLE, out=0, done=0, ready=1, err=0. No done pulse follows. A new start afterwards completes normally.
- Reset priority: reset=1 and start=1 on the same edge → remains IDLE and no done pulse appears within 10 cycles.
